// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_pkg
// Purpose  : Shared sweep-sequencer state encoding and table-width helper.
// Revision : 1.0
// ============================================================================
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_mismatch_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tt_mismatch_tracker
// Purpose  : Counts mismatching table entries and remembers the lowest one.
// Revision : 1.0
// ============================================================================
module tt_mismatch_tracker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            sample,
    input  logic [N_IN-1:0] idx,
    input  logic            mismatch,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);

    logic [N_IN:0]   fail_cnt_q,   fail_cnt_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;

    // Indices arrive in ascending order, so the first hit is the lowest one.
    always_comb begin
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        if (clear) begin
            fail_cnt_d   = '0;
            first_fail_d = '0;
        end else if (sample && mismatch) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
            if (fail_cnt_q == '0) begin
                first_fail_d = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign fail_cnt   = fail_cnt_q;
    assign first_fail = first_fail_q;

endmodule
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Purpose  : Sweeps all input vectors of a boolean unit, captures its truth
//            table and compares it against a latched expected table.
// Revision : 1.0
// ============================================================================
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN          = 3,
    parameter  int SETTLE_CYCLES = 1,
    localparam int TT_W          = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] exp_tt,
    output logic [N_IN-1:0] f_in,
    input  logic            f_out,
    output logic [TT_W-1:0] tt,
    output logic            busy,
    output logic            done,
    output logic            match,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(TT_W - 1);
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] idx_q,   idx_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [TT_W-1:0] exp_q,   exp_d;
    logic [TT_W-1:0] tt_q,    tt_d;
    logic [N_IN-1:0] f_in_q,  f_in_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            match_q, match_d;

    logic            trk_clear;
    logic            trk_sample;
    logic            mismatch;
    logic [N_IN:0]   trk_fail_cnt;
    logic [N_IN-1:0] trk_first_fail;

    assign mismatch = (f_out != exp_q[idx_q]);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        tt_d       = tt_q;
        match_d    = match_q;
        trk_clear  = 1'b0;
        trk_sample = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d     = exp_tt;
                    tt_d      = '0;
                    match_d   = 1'b0;
                    trk_clear = 1'b1;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    tt_d      = '0;
                    match_d   = 1'b0;
                    trk_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    tt_d      = '0;
                    match_d   = 1'b0;
                    trk_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tt_d[idx_q] = f_out;
                    trk_sample  = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        // Fold in the final sample so match is valid with done.
                        match_d = (trk_fail_cnt == '0) && !mismatch;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        cnt_d   = '0;
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        f_in_d = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            f_in_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            f_in_q  <= f_in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    tt_mismatch_tracker #(
        .N_IN (N_IN)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (trk_clear),
        .sample     (trk_sample),
        .idx        (idx_q),
        .mismatch   (mismatch),
        .fail_cnt   (trk_fail_cnt),
        .first_fail (trk_first_fail)
    );

    assign f_in       = f_in_q;
    assign tt         = tt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign match      = match_q;
    assign fail_cnt   = trk_fail_cnt;
    assign first_fail = trk_first_fail;

endmodule
`default_nettype wire
